// File: rtl/send_packet_arbiter_if.sv
// send_packet_arbiter_if: bundles the HC/SOF request side and the send-packet engine side of the arbiter
// Signals:
//   hc_req/hc_gnt/hc_pid/hc_wen/hc_tok       host transaction controller request, grant, PID, strobe, token
//   sof_req/sof_gnt/sof_pid/sof_wen/sof_tok  start-of-frame transmitter request, grant, PID, strobe, frame number
//   send_pid/send_wen/send_tok               muxed fields towards the send-packet engine
//   arb_err                                  sticky flag: strobe seen from a requester not holding the grant
// Modports: slave = arbiter side, master = requester/engine side (testbench).
interface send_packet_arbiter_if;
    logic        hc_req;
    logic        hc_gnt;
    logic [3:0]  hc_pid;
    logic        hc_wen;
    logic [10:0] hc_tok;
    logic        sof_req;
    logic        sof_gnt;
    logic [3:0]  sof_pid;
    logic        sof_wen;
    logic [10:0] sof_tok;
    logic [3:0]  send_pid;
    logic        send_wen;
    logic [10:0] send_tok;
    logic        arb_err;
    modport slave (
        input  hc_req, hc_pid, hc_wen, hc_tok, sof_req, sof_pid, sof_wen, sof_tok,
        output hc_gnt, sof_gnt, send_pid, send_wen, send_tok, arb_err
    );
    modport master (
        output hc_req, hc_pid, hc_wen, hc_tok, sof_req, sof_pid, sof_wen, sof_tok,
        input  hc_gnt, sof_gnt, send_pid, send_wen, send_tok, arb_err
    );
endinterface

// File: rtl/send_packet_arbiter.sv
// send_packet_arbiter: grants the send-packet engine to SOF (fixed priority) or HC and muxes the owner's fields
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    send_packet_arbiter_if.slave (requests, grants, muxed send fields, sticky arb_err)
// Parameter GAP_CYCLES (1..15): idle cycles forced between a grant release and the next grant.
module send_packet_arbiter #(
    parameter int GAP_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    send_packet_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, SOF_ACT, HC_ACT, GAP} state_t;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    // A grant is held until its owner drops the request; the other requester waits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = bus.sof_req ? SOF_ACT : bus.hc_req ? HC_ACT : IDLE;
            SOF_ACT: if (!bus.sof_req) begin
                state_d = GAP;
                cnt_d   = GAP_LOAD;
            end
            HC_ACT:  if (!bus.hc_req) begin
                state_d = GAP;
                cnt_d   = GAP_LOAD;
            end
            default: begin
                state_d = (cnt_q == '0) ? IDLE : GAP;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 4'd1;
            end
        endcase
    end
    assign err_d        = err_q | (bus.hc_wen & ~bus.hc_gnt) | (bus.sof_wen & ~bus.sof_gnt);
    assign bus.sof_gnt  = (state_q == SOF_ACT);
    assign bus.hc_gnt   = (state_q == HC_ACT);
    assign bus.send_pid = bus.sof_gnt ? bus.sof_pid : bus.hc_gnt ? bus.hc_pid : 4'd0;
    assign bus.send_wen = bus.sof_gnt ? bus.sof_wen : bus.hc_gnt ? bus.hc_wen : 1'b0;
    assign bus.send_tok = bus.sof_gnt ? bus.sof_tok : bus.hc_gnt ? bus.hc_tok : 11'd0;
    assign bus.arb_err  = err_q;
endmodule
